// File: rtl/bf_pkg.sv
// Shared Bellman-Ford constants and the result-scanner state encoding.
// The engine, the memories and the scanner all import this package.
package bf_pkg;

  localparam int BF_ADDR_W = 13;
  localparam int BF_DATA_W = 16;
  localparam int BF_DEPTH  = 8192;
  localparam logic [BF_DATA_W-1:0] BF_INF = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } scan_state_e;

endpackage

// File: rtl/bf_result_scanner_if.sv
// Output Memory read port plus the result stream, as seen by the scanner.
// The master side drives the address and the stream; the slave side supplies data and ready.
interface bf_result_scanner_if
  import bf_pkg::*;
#(
  parameter int ADDR_W = BF_ADDR_W,
  parameter int DATA_W = BF_DATA_W
);

  logic [ADDR_W-1:0] OMAR;
  logic [DATA_W-1:0] OMDR;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutData;
  logic [ADDR_W-1:0] OutIndex;
  logic              OutUnreachable;
  logic              OutLast;

  modport master (
    output OMAR, OutValid, OutData, OutIndex, OutUnreachable, OutLast,
    input  OMDR, OutReady
  );

  modport slave (
    input  OMAR, OutValid, OutData, OutIndex, OutUnreachable, OutLast,
    output OMDR, OutReady
  );

endinterface

// File: rtl/bf_scan_stats.sv
// Reachable-node counter and running maximum of finite distances.
// Both are updated only on an accepted stream entry that is not unreachable.
module bf_scan_stats
  import bf_pkg::*;
#(
  parameter int ADDR_W = BF_ADDR_W,
  parameter int DATA_W = BF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fire,
  input  logic              unreachable,
  input  logic [DATA_W-1:0] data,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] max_dist
);

  // NOTE: non-blocking assignments for all state, so the result never depends on statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      max_dist <= '0;
    end else if (fire && !unreachable) begin
      count <= count + (ADDR_W+1)'(1);
      if (data > max_dist) max_dist <= data;
    end
  end

endmodule

// File: rtl/bf_result_scanner.sv
// Walks the Output Memory after the engine finishes and streams every word with its
// index and unreachable flag; aborts without scanning if a negative cycle was reported.
module bf_result_scanner
  import bf_pkg::*;
#(
  parameter int DEPTH  = BF_DEPTH,
  parameter int ADDR_W = BF_ADDR_W,
  parameter int DATA_W = BF_DATA_W,
  parameter logic [DATA_W-1:0] INF = BF_INF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                Finish,
  input  logic                NegCycle,
  bf_result_scanner_if.master bus,
  output logic [ADDR_W:0]     ReachableCount,
  output logic [DATA_W-1:0]   MaxDistance,
  output logic                Done,
  output logic                Aborted
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  scan_state_e       state, state_n;
  logic              finish_q;
  logic [ADDR_W-1:0] ptr;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_unreach;
  logic              out_last;
  logic              start, load, fire;

  assign start = Finish && !finish_q;
  assign fire  = out_valid && bus.OutReady;
  // Once the final word sits in the output register nothing more is fetched.
  assign load  = (state == ST_SCAN) && !(out_valid && out_last) && (!out_valid || bus.OutReady);

  // NOTE: state_n gets its default before the case, so no path can infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (start) state_n = NegCycle ? ST_ABORT : ST_SCAN;
      ST_SCAN:  if (fire && out_last) state_n = ST_DONE;
      ST_DONE:  state_n = ST_DONE;
      ST_ABORT: state_n = ST_ABORT;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      finish_q    <= 1'b0;
      ptr         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      out_unreach <= 1'b0;
      out_last    <= 1'b0;
      Done        <= 1'b0;
      Aborted     <= 1'b0;
    end else begin
      state    <= state_n;
      finish_q <= Finish;

      if (state == ST_IDLE && start && !NegCycle) begin
        ptr <= '0;
      end else if (load && ptr != LAST_IDX) begin
        ptr <= ptr + ADDR_W'(1);
      end

      if (load) begin
        out_valid   <= 1'b1;
        out_data    <= bus.OMDR;
        out_index   <= ptr;
        out_unreach <= (bus.OMDR == INF);
        out_last    <= (ptr == LAST_IDX);
      end else if (fire) begin
        out_valid <= 1'b0;
      end

      // Done rises on the edge that accepts the last entry.
      if (fire && out_last) Done <= 1'b1;
      if (state == ST_ABORT) begin
        Done    <= 1'b1;
        Aborted <= 1'b1;
      end
    end
  end

  assign bus.OMAR           = (state == ST_SCAN) ? ptr : '0;
  assign bus.OutValid       = out_valid;
  assign bus.OutData        = out_data;
  assign bus.OutIndex       = out_index;
  assign bus.OutUnreachable = out_unreach;
  assign bus.OutLast        = out_last;

  bf_scan_stats #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_stats (
    .clock       (clock),
    .reset       (reset),
    .fire        (fire),
    .unreachable (out_unreach),
    .data        (out_data),
    .count       (ReachableCount),
    .max_dist    (MaxDistance)
  );

endmodule
